instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: InstructionFetch

---
 rtl/instruction_fetch.sv | 125 ++++++++++++
 tb/tb_instruction_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch FSM: one outstanding memory request, decode handshake, redirect/flush.
// Optional FETCH_MISALIGN_CHECK_EN adds an ERR state that reports misaligned redirect targets.
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`endif
`ifndef EXCEP_OK
`define EXCEP_OK 4'h0
`endif
`ifndef EXCEP_FETCH_MISALIGNED
`define EXCEP_FETCH_MISALIGNED 4'h1
`endif

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk_In,
  input  logic                      rstN_In,
  output logic [31:0]               memAddr_Out,
  output logic                      memReq_Out,
  input  logic                      memAck_In,
  input  logic [31:0]               memData_In,
  output logic [31:0]               instr_Out,
  output logic [31:0]               pc_Out,
  output logic                      instrValid_Out,
  input  logic                      decodeReady_In,
  input  logic                      redirect_In,
  input  logic [31:0]               redirectPc_In,
  output logic [`EXCEPTION_LEN-1:0] exception_Out
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] HOLD  = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [2:0] ERR   = 3'd4;
`endif

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] flush_addr;  // address of the abandoned request while draining in FLUSH
  logic [31:0] redirect_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic [`EXCEPTION_LEN-1:0] exc_q;
  assign redirect_tgt  = redirectPc_In;
  assign exception_Out = exc_q;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = &{1'b0, redirectPc_In[1:0]};
  assign redirect_tgt        = {redirectPc_In[31:2], 2'b00};
  assign exception_Out       = `EXCEP_OK;
`endif

  assign memReq_Out  = (state == REQ) || (state == FLUSH);
  assign memAddr_Out = (state == FLUSH) ? flush_addr :
                       (state == REQ)   ? pc         : 32'h0000_0000;

  always_ff @(posedge clk_In) begin
    if (!rstN_In) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      flush_addr     <= 32'h0000_0000;
      instr_Out      <= 32'h0000_0000;
      pc_Out         <= 32'h0000_0000;
      instrValid_Out <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      exc_q          <= `EXCEP_OK;
`endif
    end else if (redirect_In) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (|redirectPc_In[1:0]) begin
        state          <= ERR;
        instr_Out      <= 32'h0000_0000;
        pc_Out         <= redirectPc_In;
        instrValid_Out <= 1'b1;
        exc_q          <= `EXCEP_FETCH_MISALIGNED;
      end else
`endif
      begin
        pc             <= redirect_tgt;
        instrValid_Out <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        exc_q          <= `EXCEP_OK;
`endif
        // An unacknowledged request must drain before the new pc can be issued
        if (state == REQ && !memAck_In) begin
          flush_addr <= pc;
          state      <= FLUSH;
        end else if (state == FLUSH && !memAck_In) begin
          state <= FLUSH;
        end else begin
          state <= REQ;
        end
      end
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (memAck_In) begin
            instr_Out      <= memData_In;
            pc_Out         <= pc;
            instrValid_Out <= 1'b1;
            pc             <= pc + 32'd4;
            state          <= HOLD;
          end
        end
        HOLD: begin
          if (decodeReady_In) begin
            instrValid_Out <= 1'b0;
            state          <= REQ;
          end
        end
        FLUSH: begin
          if (memAck_In) state <= REQ;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        ERR: state <= ERR;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, wait states, stall, redirect/flush, wrap, misalign.
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`endif
`ifndef EXCEP_OK
`define EXCEP_OK 4'h0
`endif
`ifndef EXCEP_FETCH_MISALIGNED
`define EXCEP_FETCH_MISALIGNED 4'h1
`endif

module tb_instruction_fetch;

  logic                      clk_In = 1'b0;
  logic                      rstN_In;
  logic [31:0]               memAddr_Out;
  logic                      memReq_Out;
  logic                      memAck_In;
  logic [31:0]               memData_In;
  logic [31:0]               instr_Out;
  logic [31:0]               pc_Out;
  logic                      instrValid_Out;
  logic                      decodeReady_In;
  logic                      redirect_In;
  logic [31:0]               redirectPc_In;
  logic [`EXCEPTION_LEN-1:0] exception_Out;

  int n_cmp = 0;
  int n_bad = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_In         (clk_In),
    .rstN_In        (rstN_In),
    .memAddr_Out    (memAddr_Out),
    .memReq_Out     (memReq_Out),
    .memAck_In      (memAck_In),
    .memData_In     (memData_In),
    .instr_Out      (instr_Out),
    .pc_Out         (pc_Out),
    .instrValid_Out (instrValid_Out),
    .decodeReady_In (decodeReady_In),
    .redirect_In    (redirect_In),
    .redirectPc_In  (redirectPc_In),
    .exception_Out  (exception_Out)
  );

  always #5 clk_In = ~clk_In;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  // Memory returns a word derived from the address it was asked for; garbage when not acking
  assign memData_In = memAck_In ? mem_word(memAddr_Out) : 32'hDEAD_BEEF;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_In);
    #1;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    check_eq({tag, "_req"}, 32'(memReq_Out), 32'd1);
    check_eq({tag, "_addr"}, memAddr_Out, addr);
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] pc);
    check_eq({tag, "_vld"}, 32'(instrValid_Out), 32'd1);
    check_eq({tag, "_pc"}, pc_Out, pc);
    check_eq({tag, "_instr"}, instr_Out, mem_word(pc));
    check_eq({tag, "_noreq"}, 32'(memReq_Out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN_In = 1'b0; memAck_In = 1'b1; decodeReady_In = 1'b1;
    redirect_In = 1'b0; redirectPc_In = 32'h0;
    tick(); tick();
    check_eq("rst_req",   32'(memReq_Out), 32'd0);
    check_eq("rst_addr",  memAddr_Out, 32'h0);
    check_eq("rst_vld",   32'(instrValid_Out), 32'd0);
    check_eq("rst_instr", instr_Out, 32'h0);
    check_eq("rst_pc",    pc_Out, 32'h0);
    check_eq("rst_exc",   32'(exception_Out), 32'(`EXCEP_OK));

    // Zero-wait streaming: valid every second cycle, pc 0,4,8
    rstN_In = 1'b1;
    tick(); expect_req("s0", 32'h0); check_eq("s0_vld", 32'(instrValid_Out), 32'd0);
    tick(); expect_instr("s0", 32'h0);
    tick(); expect_req("s1", 32'h4); check_eq("s1_vld", 32'(instrValid_Out), 32'd0);
    tick(); expect_instr("s1", 32'h4);
    tick(); expect_req("s2", 32'h8);
    tick(); expect_instr("s2", 32'h8);

    // Decode stall for five cycles: output frozen, no request
    decodeReady_In = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); expect_instr("stall", 32'h8);
    end

    // Three wait states: request/address stable for four cycles
    decodeReady_In = 1'b1; memAck_In = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_req("wait", 32'hC);
      check_eq("wait_vld", 32'(instrValid_Out), 32'd0);
    end
    memAck_In = 1'b1;
    tick(); expect_instr("wait", 32'hC);

    // Redirect while request outstanding: drain old address, then fetch target
    memAck_In = 1'b0;
    tick(); expect_req("fl_pre", 32'h10);
    redirect_In = 1'b1; redirectPc_In = 32'h100;
    tick(); expect_req("fl0", 32'h10); check_eq("fl0_vld", 32'(instrValid_Out), 32'd0);
    redirect_In = 1'b0;
    tick(); expect_req("fl1", 32'h10);
    memAck_In = 1'b1;
    tick(); expect_req("fl_new", 32'h100); check_eq("fl_drop", 32'(instrValid_Out), 32'd0);
    tick(); expect_instr("fl_new", 32'h100);

    // Redirect in HOLD with simultaneous accept drops the held instruction; pc wraps
    redirect_In = 1'b1; redirectPc_In = 32'hFFFF_FFFC;
    tick(); expect_req("wr0", 32'hFFFF_FFFC); check_eq("wr0_vld", 32'(instrValid_Out), 32'd0);
    redirect_In = 1'b0;
    tick(); expect_instr("wr0", 32'hFFFF_FFFC);
    tick(); expect_req("wr1", 32'h0);
    tick(); expect_instr("wr1", 32'h0);

    // Redirect in REQ with ack: returned data discarded
    tick(); expect_req("ra_pre", 32'h4);
    redirect_In = 1'b1; redirectPc_In = 32'h200;
    tick(); expect_req("ra", 32'h200); check_eq("ra_vld", 32'(instrValid_Out), 32'd0);
    redirect_In = 1'b0;
    tick(); expect_instr("ra", 32'h200);

    // Misaligned redirect target
    redirect_In = 1'b1; redirectPc_In = 32'h102;
`ifdef FETCH_MISALIGN_CHECK_EN
    tick();
    redirect_In = 1'b0;
    check_eq("mis_exc",   32'(exception_Out), 32'(`EXCEP_FETCH_MISALIGNED));
    check_eq("mis_vld",   32'(instrValid_Out), 32'd1);
    check_eq("mis_instr", instr_Out, 32'h0);
    check_eq("mis_pc",    pc_Out, 32'h102);
    check_eq("mis_req",   32'(memReq_Out), 32'd0);
    tick(); check_eq("mis_stay", 32'(memReq_Out), 32'd0);
    check_eq("mis_stay_exc", 32'(exception_Out), 32'(`EXCEP_FETCH_MISALIGNED));
    redirect_In = 1'b1; redirectPc_In = 32'h300;
    tick(); redirect_In = 1'b0;
    expect_req("mis_exit", 32'h300);
    check_eq("mis_exit_exc", 32'(exception_Out), 32'(`EXCEP_OK));
    check_eq("mis_exit_vld", 32'(instrValid_Out), 32'd0);
`else
    tick();
    redirect_In = 1'b0;
    expect_req("mis", 32'h100);
    check_eq("mis_exc", 32'(exception_Out), 32'(`EXCEP_OK));
    tick(); expect_instr("mis", 32'h100);
`endif

    // Reset mid-request drops the request; a stray ack after it is ignored
    tick();
    memAck_In = 1'b0;
    tick();
    rstN_In = 1'b0;
    tick();
    check_eq("mrst_req", 32'(memReq_Out), 32'd0);
    check_eq("mrst_vld", 32'(instrValid_Out), 32'd0);
    rstN_In = 1'b1; memAck_In = 1'b1;
    tick();
    check_eq("mrst_idle_vld", 32'(instrValid_Out), 32'd0);
    expect_req("mrst", 32'h0);
    tick(); expect_instr("mrst", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
